i2c_byte_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one i2c_master_single_byte instance between NUM_REQ on-chip requesters. Each requester posts a single-byte read or write. The block grants one requester, drives the master's start and address/data inputs, and tracks o_busy to completion or timeout. It then returns read data and a status code to the granted requester. It sits between the sensor/config logic and the I2C master.

---
 rtl/i2c_arb_pkg.sv | 30 +++
 rtl/i2c_rr_arbiter.sv | 35 +++
 rtl/i2c_byte_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_i2c_byte_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C byte arbiter.
//   state_t      : sequencer states
//   ERR_*        : completion status codes returned on o_err_code
//   timer_width  : bits needed to count up to the largest timeout limit
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RECOVER,
        COMPLETE
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_NACK     = 2'b01;
    localparam logic [1:0] ERR_START_TO = 2'b10;
    localparam logic [1:0] ERR_XFER_TO  = 2'b11;

    // The timer only ever counts to (limit - 1), so clog2(limit) bits suffice.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin picker.
//   i_req   : request vector
//   i_start : index where the search begins (owned by the parent)
//   o_gnt   : one-hot winner, all zero when nothing requests
//   o_idx   : binary index of the winner
//   o_any   : at least one request present
module i2c_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_start,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    always_comb begin
        int cand;
        cand  = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(i_start) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!o_any && i_req[cand]) begin
                o_any       = 1'b1;
                o_gnt[cand] = 1'b1;
                o_idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_byte_arbiter.sv
// Round-robin sequencer sharing one single-byte I2C master between NUM_REQ
// requesters. A winner is latched, one start pulse is issued, the master's
// busy flag is tracked to completion or timeout, and the result is returned
// with a one-cycle o_done pulse.
//   i_req/i_req_rd/i_req_addr/i_req_wdata : per-requester request, packed
//   o_gnt, o_done, o_rdata, o_err_code   : grant and completion back to requesters
//   o_m_* / i_m_*                        : connection to the I2C master
// All outputs are registered so they read zero during reset.
module i2c_byte_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int START_TIMEOUT  = 16,
    parameter int XFER_TIMEOUT   = 65535,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ-1:0]     i_req_rd,
    input  logic [7*NUM_REQ-1:0]   i_req_addr,
    input  logic [8*NUM_REQ-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [NUM_REQ-1:0]     o_done,
    output logic [7:0]             o_rdata,
    output logic [1:0]             o_err_code,
    output logic                   o_m_enable,
    output logic [6:0]             o_m_slave_addr,
    output logic                   o_m_wr_start,
    output logic                   o_m_rd_start,
    output logic [7:0]             o_m_wr_byte,
    input  logic                   i_m_busy,
    input  logic [7:0]             i_m_rd_byte,
    input  logic                   i_m_error
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = timer_width(START_TIMEOUT, XFER_TIMEOUT, RECOVER_CYCLES);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic                 rd_q, rd_d;
    logic [6:0]           addr_q, addr_d;
    logic [7:0]           wbyte_q, wbyte_d;
    logic [7:0]           rdata_q, rdata_d;
    logic [1:0]           err_q, err_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 en_q, en_d;
    logic                 wr_start_q, wr_start_d;
    logic                 rd_start_q, rd_start_d;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;

    logic start_to, xfer_to, recover_end;
    assign start_to    = (timer_q == TW'(START_TIMEOUT - 1));
    assign xfer_to     = (timer_q == TW'(XFER_TIMEOUT - 1));
    assign recover_end = (timer_q == TW'(RECOVER_CYCLES - 1));

    i2c_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .i_req   (i_req),
        .i_start (ptr_q),
        .o_gnt   (pick_gnt),
        .o_idx   (pick_idx),
        .o_any   (pick_any)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pick_any) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (i_m_busy)      state_d = WAIT_DONE;
                else if (start_to) state_d = COMPLETE;
            end
            WAIT_DONE: begin
                if (!i_m_busy)    state_d = COMPLETE;
                else if (xfer_to) state_d = RECOVER;
            end
            RECOVER:   if (recover_end) state_d = COMPLETE;
            COMPLETE:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so that the grant and the
    // start pulse appear in the cycle right after the request is sampled.
    always_comb begin
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wbyte_d = wbyte_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        timer_d = timer_q + 1'b1;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    rd_d    = i_req_rd[pick_idx];
                    addr_d  = i_req_addr[7*pick_idx +: 7];
                    wbyte_d = i_req_wdata[8*pick_idx +: 8];
                end
            end
            START: timer_d = '0;
            WAIT_BUSY: begin
                if (i_m_busy)      timer_d = '0;
                else if (start_to) err_d   = ERR_START_TO;
            end
            WAIT_DONE: begin
                if (!i_m_busy) begin
                    if (rd_q) rdata_d = i_m_rd_byte;
                    err_d = i_m_error ? ERR_NACK : ERR_OK;
                end else if (xfer_to) begin
                    err_d   = ERR_XFER_TO;
                    timer_d = '0;
                end
            end
            RECOVER: ;
            COMPLETE: begin
                gnt_d   = '0;
                timer_d = '0;
                // The winner moves to lowest priority for the next search.
                ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: timer_d = '0;
        endcase
        done_d     = (state_d == COMPLETE) ? gnt_q : '0;
        wr_start_d = (state_d == START) && !rd_d;
        rd_start_d = (state_d == START) && rd_d;
        en_d       = (state_d != RECOVER);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt_q      <= '0;
            done_q     <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            wbyte_q    <= '0;
            rdata_q    <= '0;
            err_q      <= ERR_OK;
            timer_q    <= '0;
            en_q       <= 1'b0;
            wr_start_q <= 1'b0;
            rd_start_q <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wbyte_q    <= wbyte_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            en_q       <= en_d;
            wr_start_q <= wr_start_d;
            rd_start_q <= rd_start_d;
        end
    end

    assign o_gnt          = gnt_q;
    assign o_done         = done_q;
    assign o_rdata        = rdata_q;
    assign o_err_code     = err_q;
    assign o_m_enable     = en_q;
    assign o_m_slave_addr = addr_q;
    assign o_m_wr_start   = wr_start_q;
    assign o_m_rd_start   = rd_start_q;
    assign o_m_wr_byte    = wbyte_q;

endmodule

// File: tb/tb_i2c_byte_arbiter.sv
// Scoreboard bench for i2c_byte_arbiter with a behavioural I2C master model.
module tb_i2c_byte_arbiter;
    import i2c_arb_pkg::*;

    localparam int N  = 4;
    localparam int ST = 16;
    localparam int XT = 200;
    localparam int RC = 4;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req;
    logic [N-1:0]   i_req_rd;
    logic [7*N-1:0] i_req_addr;
    logic [8*N-1:0] i_req_wdata;
    logic [N-1:0]   o_gnt;
    logic [N-1:0]   o_done;
    logic [7:0]     o_rdata;
    logic [1:0]     o_err_code;
    logic           o_m_enable;
    logic [6:0]     o_m_slave_addr;
    logic           o_m_wr_start;
    logic           o_m_rd_start;
    logic [7:0]     o_m_wr_byte;
    logic           i_m_busy;
    logic [7:0]     i_m_rd_byte;
    logic           i_m_error;

    i2c_byte_arbiter #(
        .NUM_REQ        (N),
        .START_TIMEOUT  (ST),
        .XFER_TIMEOUT   (XT),
        .RECOVER_CYCLES (RC)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req          (i_req),
        .i_req_rd       (i_req_rd),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_gnt          (o_gnt),
        .o_done         (o_done),
        .o_rdata        (o_rdata),
        .o_err_code     (o_err_code),
        .o_m_enable     (o_m_enable),
        .o_m_slave_addr (o_m_slave_addr),
        .o_m_wr_start   (o_m_wr_start),
        .o_m_rd_start   (o_m_rd_start),
        .o_m_wr_byte    (o_m_wr_byte),
        .i_m_busy       (i_m_busy),
        .i_m_rd_byte    (i_m_rd_byte),
        .i_m_error      (i_m_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         idx;
        logic       rd;
        logic [6:0] addr;
        logic [7:0] wbyte;
    } start_t;

    typedef struct {
        int         idx;
        logic [7:0] rdata;
        logic [1:0] err;
    } done_t;

    start_t     exp_start[$];
    done_t      exp_done[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         model_delay = 1;
    int         model_len = 1;
    logic [7:0] exp_rdata = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] all_outs();
        return {o_gnt, o_done, o_rdata, o_err_code, o_m_enable, o_m_slave_addr,
                o_m_wr_start, o_m_rd_start, o_m_wr_byte};
    endfunction

    task automatic set_model(input int d, input int l, input logic [7:0] rb, input logic e);
        model_delay = d;
        model_len   = l;
        i_m_rd_byte = rb;
        i_m_error   = e;
    endtask

    task automatic set_req(input int k, input logic rd, input logic [6:0] a, input logic [7:0] w);
        i_req_rd[k]          = rd;
        i_req_addr[7*k +: 7]  = a;
        i_req_wdata[8*k +: 8] = w;
    endtask

    task automatic expect_start(input int k);
        start_t s;
        s.idx   = k;
        s.rd    = i_req_rd[k];
        s.addr  = i_req_addr[7*k +: 7];
        s.wbyte = i_req_wdata[8*k +: 8];
        exp_start.push_back(s);
    endtask

    // Reads capture the master byte unless the transfer timed out.
    task automatic expect_xfer(input int k, input logic [1:0] err);
        done_t d;
        expect_start(k);
        if (i_req_rd[k] && (err == ERR_OK || err == ERR_NACK)) exp_rdata = i_m_rd_byte;
        d.idx   = k;
        d.rdata = exp_rdata;
        d.err   = err;
        exp_done.push_back(d);
    endtask

    task automatic wait_done(input int target, input string name);
        int c;
        c = 0;
        while (done_cnt < target && c < 2000) begin
            @(posedge i_clk);
            #2;
            c++;
        end
        if (done_cnt < target) check({name, "_timeout"}, done_cnt, target);
    endtask

    task automatic pulse_reset(input string name);
        @(posedge i_clk);
        #3 i_rst = 1'b1;
        #1 check(name, all_outs(), 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_rst = 1'b0;
        exp_rdata = 8'h00;
        @(posedge i_clk);
        #2;
    endtask

    // Busy rises model_delay cycles after a start pulse and stays high for
    // model_len cycles; model_len 0 means busy never rises. Disabling the
    // master or resetting drops busy at once.
    task automatic master_model();
        int d;
        int l;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst) begin
                i_m_busy = 1'b0;
            end else if (o_m_wr_start || o_m_rd_start) begin
                d = model_delay;
                l = model_len;
                if (l > 0) begin
                    repeat (d) @(posedge i_clk);
                    #1 i_m_busy = 1'b1;
                    for (int c = 0; c < l; c++) begin
                        @(posedge i_clk);
                        #1;
                        if (i_rst || !o_m_enable) break;
                    end
                    i_m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic monitor();
        int     starts;
        int     run;
        start_t s;
        done_t  d;
        starts = 0;
        run    = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                starts = 0;
                run    = 0;
                continue;
            end
            if (o_gnt != '0) check("gnt_onehot", $onehot(o_gnt), 1);
            if (o_m_wr_start || o_m_rd_start) begin
                check("start_exclusive", o_m_wr_start & o_m_rd_start, 0);
                if (exp_start.size() == 0) begin
                    check("start_unexpected", {o_m_wr_start, o_m_rd_start}, 0);
                end else begin
                    s = exp_start.pop_front();
                    check("start_gnt", o_gnt, 1 << s.idx);
                    check("start_rd", o_m_rd_start, s.rd);
                    check("start_addr", o_m_slave_addr, s.addr);
                    if (!s.rd) check("start_wbyte", o_m_wr_byte, s.wbyte);
                end
                starts++;
            end
            if (o_done != '0) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    check("done_unexpected", o_done, 0);
                end else begin
                    d = exp_done.pop_front();
                    check("done_vec", o_done, 1 << d.idx);
                    check("done_rdata", o_rdata, d.rdata);
                    check("done_err", o_err_code, d.err);
                    check("starts_per_grant", starts, 1);
                end
                starts = 0;
            end
            if (!o_m_enable && o_gnt != '0) begin
                run++;
            end else if (run != 0) begin
                check("recover_len", run, RC);
                run = 0;
            end
        end
    endtask

    initial begin
        int c;
        i_rst       = 1'b0;
        i_req       = '0;
        i_req_rd    = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_m_busy    = 1'b0;
        i_m_rd_byte = 8'h00;
        i_m_error   = 1'b0;
        #1 i_rst = 1'b1;
        #1 check("reset_outputs", all_outs(), 0);
        fork
            master_model();
            monitor();
        join_none
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_rst = 1'b0;
        @(posedge i_clk);
        #2;
        check("enable_after_reset", o_m_enable, 1);

        // single write from requester 0
        set_model(2, 100, 8'h00, 1'b0);
        set_req(0, 1'b0, 7'h50, 8'hAC);
        expect_xfer(0, ERR_OK);
        i_req[0] = 1'b1;
        wait_done(1, "t1");
        i_req[0] = 1'b0;

        // single read from requester 2
        set_model(2, 20, 8'h5A, 1'b0);
        set_req(2, 1'b1, 7'h1E, 8'h00);
        expect_xfer(2, ERR_OK);
        i_req[2] = 1'b1;
        wait_done(2, "t2");
        i_req[2] = 1'b0;
        repeat (3) @(posedge i_clk);
        #2 check("t2_rdata_held", o_rdata, 8'h5A);

        // all requesters at once from a fresh pointer: order 0,1,2,3,0
        pulse_reset("t3_reset");
        set_model(1, 3, 8'h00, 1'b0);
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 7'h10 + 7'(k), 8'hA0 + 8'(k));
        expect_xfer(0, ERR_OK);
        expect_xfer(1, ERR_OK);
        expect_xfer(2, ERR_OK);
        expect_xfer(3, ERR_OK);
        expect_xfer(0, ERR_OK);
        i_req = '1;
        wait_done(7, "t3");
        i_req = '0;

        // busy never rises: start timeout, read data not captured
        set_model(1, 0, 8'hEE, 1'b0);
        set_req(1, 1'b1, 7'h2B, 8'h00);
        expect_xfer(1, ERR_START_TO);
        i_req[1] = 1'b1;
        wait_done(8, "t4");
        i_req[1] = 1'b0;

        // busy stuck high: transfer timeout with recovery
        set_model(1, 100000, 8'h00, 1'b0);
        set_req(3, 1'b0, 7'h44, 8'h5C);
        expect_xfer(3, ERR_XFER_TO);
        i_req[3] = 1'b1;
        wait_done(9, "t5_xfer_to");
        i_req[3] = 1'b0;

        // master error reported as NACK
        set_model(1, 5, 8'h00, 1'b1);
        set_req(1, 1'b0, 7'h45, 8'h11);
        expect_xfer(1, ERR_NACK);
        i_req[1] = 1'b1;
        wait_done(10, "t5_nack");
        i_req[1] = 1'b0;
        i_m_error = 1'b0;

        // reset in the middle of a transfer, then requester 0 served first
        set_model(1, 100000, 8'h00, 1'b0);
        set_req(0, 1'b1, 7'h33, 8'h00);
        expect_start(0);
        i_req[0] = 1'b1;
        c = 0;
        while (!i_m_busy && c < 100) begin
            @(posedge i_clk);
            #2;
            c++;
        end
        if (!i_m_busy) check("t6_busy_timeout", i_m_busy, 1);
        repeat (3) @(posedge i_clk);
        #3 i_rst = 1'b1;
        #1 check("t6_async_reset", all_outs(), 0);
        set_model(1, 3, 8'h3C, 1'b0);
        set_req(2, 1'b0, 7'h22, 8'h99);
        i_req[2] = 1'b1;
        exp_rdata = 8'h00;
        expect_xfer(0, ERR_OK);
        expect_xfer(2, ERR_OK);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_rst = 1'b0;
        wait_done(11, "t6_req0");
        i_req[0] = 1'b0;
        wait_done(12, "t6_req2");
        i_req[2] = 1'b0;

        repeat (5) @(posedge i_clk);
        #2 check("queues_empty", exp_start.size() + exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
